// File: rtl/matrix_rd_arbiter.sv
// matrix_rd_arbiter: round-robin owner of the single combinational matrix_mem read port.
// The owner's slot/row/col goes to memory. Read data and dimensions are broadcast to everyone.
// Optional macro MATRIX_RD_ARB_TIMEOUT_EN enables burst preemption after MAX_HOLD cycles.
module matrix_rd_arbiter #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_slot,
    input  logic [3*N_REQ-1:0]   req_row,
    input  logic [3*N_REQ-1:0]   req_col,
    output logic [N_REQ-1:0]     gnt,
    output logic [15:0]          rd_data,
    output logic [2:0]           rd_m,
    output logic [2:0]           rd_n,
    output logic [1:0]           mem_rd_slot,
    output logic [2:0]           mem_rd_row,
    output logic [2:0]           mem_rd_col,
    input  logic [15:0]          mem_rd_data,
    input  logic [2:0]           mem_cur_m,
    input  logic [2:0]           mem_cur_n,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 4 || MAX_HOLD < 2) begin : g_param_check
        $error("matrix_rd_arbiter: N_REQ must be 2..4 and MAX_HOLD at least 2");
    end

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q;

    // Index after i, wrapping at N_REQ.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == int'(N_REQ) - 1) return '0;
        return i + 1'b1;
    endfunction

    // First set bit of mask searching upward from start with wrap.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                              input logic [IW-1:0] start);
        logic [IW-1:0] win;
        logic [IW-1:0] idx;
        win = start;
        // Walk from the farthest offset down so the nearest candidate wins last.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            idx = IW'((int'(start) + k) % int'(N_REQ));
            if (mask[idx]) win = idx;
        end
        return win;
    endfunction

    function automatic logic [N_REQ-1:0] to_oh(input logic [IW-1:0] i);
        logic [N_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

`ifdef MATRIX_RD_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
    logic [N_REQ-1:0] others;

    // Hold counter and preemption pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign others  = req & ~to_oh(owner_q);
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            busy_q  <= |gnt_d;
        end
    end

    // Next-state: grant from IDLE, hold/release/handoff while owned.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
`ifdef MATRIX_RD_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d = rr_pick(req, ptr_q);
                    gnt_d   = to_oh(owner_d);
                    state_d = StOwn;
`ifdef MATRIX_RD_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            StOwn: begin
                if (!req[owner_q]) begin
                    // Release; hand off in the same edge if anyone else waits.
                    ptr_d = next_idx(owner_q);
                    if (|req) begin
                        owner_d = rr_pick(req, ptr_d);
                        gnt_d   = to_oh(owner_d);
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
`ifdef MATRIX_RD_ARB_TIMEOUT_EN
                    hold_d = '0;
                end else if (hold_q == HW'(MAX_HOLD - 1) && |others) begin
                    // Preempt a long burst; the owner remains eligible later.
                    ptr_d     = next_idx(owner_q);
                    owner_d   = rr_pick(others, ptr_d);
                    gnt_d     = to_oh(owner_d);
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // Owner address mux onto the memory port; zero when nobody is granted.
    always_comb begin
        mem_rd_slot = '0;
        mem_rd_row  = '0;
        mem_rd_col  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt_q[i]) begin
                mem_rd_slot = req_slot[2*i +: 2];
                mem_rd_row  = req_row[3*i +: 3];
                mem_rd_col  = req_col[3*i +: 3];
            end
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign rd_data = mem_rd_data;
    assign rd_m    = mem_cur_m;
    assign rd_n    = mem_cur_n;

endmodule

// File: tb/tb_matrix_rd_arbiter.sv
// Self-checking bench for matrix_rd_arbiter with a behavioural arbitration model
// and a small combinational matrix_mem stand-in.
module tb_matrix_rd_arbiter;

    localparam int N  = 3;
    localparam int MH = 8;
`ifdef MATRIX_RD_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [2*N-1:0] req_slot;
    logic [3*N-1:0] req_row;
    logic [3*N-1:0] req_col;
    logic [N-1:0]  gnt;
    logic [15:0]   rd_data;
    logic [2:0]    rd_m;
    logic [2:0]    rd_n;
    logic [1:0]    mem_rd_slot;
    logic [2:0]    mem_rd_row;
    logic [2:0]    mem_rd_col;
    logic [15:0]   mem_rd_data;
    logic [2:0]    mem_cur_m;
    logic [2:0]    mem_cur_n;
    logic          busy;
    logic          timeout;

    matrix_rd_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_slot    (req_slot),
        .req_row     (req_row),
        .req_col     (req_col),
        .gnt         (gnt),
        .rd_data     (rd_data),
        .rd_m        (rd_m),
        .rd_n        (rd_n),
        .mem_rd_slot (mem_rd_slot),
        .mem_rd_row  (mem_rd_row),
        .mem_rd_col  (mem_rd_col),
        .mem_rd_data (mem_rd_data),
        .mem_cur_m   (mem_cur_m),
        .mem_cur_n   (mem_cur_n),
        .busy        (busy),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in.
    logic [15:0] mem [4][8][8];
    logic [2:0]  dm [4];
    logic [2:0]  dn [4];
    assign mem_rd_data = mem[mem_rd_slot][mem_rd_row][mem_rd_col];
    assign mem_cur_m   = dm[mem_rd_slot];
    assign mem_cur_n   = dn[mem_rd_slot];

    // Requester addresses.
    int rs [N] = '{1, 2, 3};
    int rr [N] = '{0, 1, 4};
    int rc [N] = '{3, 2, 5};

    // Model state: owner index (-1 none), pointer, burst length, preemption pulse.
    int m_own, m_ptr, m_hold;
    bit m_to;
    int n_checks, n_err;

    function automatic int first_from(input logic [N-1:0] mask, input int start);
        for (int k = 0; k < N; k++) begin
            if (mask[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] others;
        m_to = 1'b0;
        if (rst) begin
            m_own = -1; m_ptr = 0; m_hold = 0;
        end else if (m_own < 0) begin
            if (req != 0) begin
                m_own = first_from(req, m_ptr); m_hold = 0;
            end
        end else if (req[m_own]) begin
            others = req;
            others[m_own] = 1'b0;
            if (TO_EN && m_hold == MH - 1 && others != 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = first_from(others, m_ptr);
                m_hold = 0;
                m_to = 1'b1;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end else begin
            m_ptr = (m_own + 1) % N;
            m_hold = 0;
            m_own = (req != 0) ? first_from(req, m_ptr) : -1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic compare();
        logic [N-1:0] eg;
        int es, er, ec;
        eg = '0;
        es = 0; er = 0; ec = 0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            es = rs[m_own]; er = rr[m_own]; ec = rc[m_own];
        end
        chk("gnt", 16'(gnt), 16'(eg));
        chk("busy", 16'(busy), 16'(m_own >= 0));
        chk("timeout", 16'(timeout), 16'(m_to));
        chk("mem_rd_slot", 16'(mem_rd_slot), 16'(es));
        chk("mem_rd_row", 16'(mem_rd_row), 16'(er));
        chk("mem_rd_col", 16'(mem_rd_col), 16'(ec));
        chk("rd_data", rd_data, mem[es][er][ec]);
        chk("rd_m", 16'(rd_m), 16'(dm[es]));
        chk("rd_n", 16'(rd_n), 16'(dn[es]));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_err = 0;
        m_own = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem[s][r][c] = 16'hA000 | 16'(s << 8) | 16'(r << 4) | 16'(c);
        mem[2][1][2] = 16'h0007;
        dm = '{3'd1, 3'd2, 3'd3, 3'd4};
        dn = '{3'd5, 3'd6, 3'd4, 3'd7};
        for (int i = 0; i < N; i++) begin
            req_slot[2*i +: 2] = 2'(rs[i]);
            req_row[3*i +: 3]  = 3'(rr[i]);
            req_col[3*i +: 3]  = 3'(rc[i]);
        end

        // 1. Reset with all requests high.
        rst = 1'b1; req = 3'b111;
        @(negedge clk);
        tick(); tick();
        chk("rst_gnt", 16'(gnt), 16'h0);
        chk("rst_slot", 16'(mem_rd_slot), 16'h0);
        rst = 1'b0;
        tick();
        chk("first_gnt", 16'(gnt), 16'b001);
        req = 3'b000;
        tick();

        // 2. Single request from requester 1.
        req = 3'b010;
        tick();
        chk("single_gnt", 16'(gnt), 16'b010);
        chk("single_slot", 16'(mem_rd_slot), 16'd2);
        chk("single_data", rd_data, 16'h0007);
        chk("single_m", 16'(rd_m), 16'd3);
        chk("single_n", 16'(rd_n), 16'd4);
        req = 3'b000;
        tick();
        chk("single_rel", 16'(gnt), 16'h0);

        // Short pulse between edges must never be granted.
        req = 3'b100;
        #2 req = 3'b000;
        tick();
        chk("glitch", 16'(gnt), 16'h0);

        // 3. All three from IDLE with a fresh pointer, 3-cycle bursts each.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 3'b111;
        tick(); tick(); tick();
        req = 3'b110;
        tick();
        chk("burst_h1", 16'(gnt), 16'b010);
        tick(); tick();
        req = 3'b100;
        tick();
        chk("burst_h2", 16'(gnt), 16'b100);
        tick(); tick();
        req = 3'b000;
        tick();

        // 4. Round-robin: owner 1 releases with 0 and 2 pending.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 3'b010;
        tick();
        req = 3'b111;
        tick();
        req = 3'b101;
        tick();
        chk("rr_to2", 16'(gnt), 16'b100);
        req = 3'b001;
        tick();
        chk("rr_to0", 16'(gnt), 16'b001);
        req = 3'b000;
        tick();

        // 5. Reset in the middle of a burst.
        req = 3'b010;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst_gnt", 16'(gnt), 16'h0);
        chk("midrst_busy", 16'(busy), 16'h0);
        rst = 1'b0; req = 3'b001;
        tick();
        chk("postrst_gnt", 16'(gnt), 16'b001);
        req = 3'b000;
        tick();

        // 6. Long burst with a competitor arriving in grant cycle 2.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 3'b001;
        tick(); tick();
        req = 3'b011;
        for (int k = 0; k < 6; k++) tick();
        chk("hold8_gnt", 16'(gnt), 16'b001);
        tick();
        if (TO_EN) begin
            chk("preempt_gnt", 16'(gnt), 16'b010);
            chk("preempt_pulse", 16'(timeout), 16'h1);
        end else begin
            chk("nopreempt_gnt", 16'(gnt), 16'b001);
            chk("nopreempt_to", 16'(timeout), 16'h0);
        end
        tick(); tick();
        req = 3'b000;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
